// File: rtl/shift_rows_unit_if.sv
//==============================================================================
// Module      : shift_rows_unit_if
// Description : Valid/ready beat interface for the ShiftRows engine, with an
//               input side (state + direction) and an output side (state).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface shift_rows_unit_if #(
    parameter int NB = 4
);
    localparam int W = 32 * NB;

    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [W-1:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_state;

    modport master (
        output in_valid, in_inv, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_inv, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

`default_nettype wire

// File: rtl/shift_rows_unit.sv
//==============================================================================
// Module      : shift_rows_unit
// Description : Registered ShiftRows / InvShiftRows engine (NB = 4/6/8) feeding
//               a 2-entry output FIFO. Optional macro SHIFT_ROWS_SELFCHECK_EN
//               adds a per-pop inverse-transform check with sticky chk_err.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_rows_unit #(
    parameter int NB    = 4,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    shift_rows_unit_if.slave      bus,
    output logic [CNT_W-1:0]      blk_cnt
`ifdef SHIFT_ROWS_SELFCHECK_EN
    ,
    output logic                  chk_err
`endif
);

    localparam int W = 32 * NB;

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_unit: NB must be 4, 6 or 8");
        end
    endgenerate

    // Wide blocks (NB=8) use the larger offsets for rows 2 and 3.
    function automatic int f_off(input int r);
        int o;
        case (r)
            0:       o = 0;
            1:       o = 1;
            2:       o = (NB == 8) ? 3 : 2;
            default: o = (NB == 8) ? 4 : 3;
        endcase
        return o;
    endfunction

    function automatic logic [W-1:0] f_shift(input logic [W-1:0] s, input logic inv);
        logic [W-1:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - f_off(r) + NB) % NB : (c + f_off(r)) % NB;
                o[W-1-8*(4*c+r) -: 8] = s[W-1-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    logic [W-1:0]     entry_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;

    logic             w_push;
    logic             w_pop;
    logic [W-1:0]     w_shifted;

    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_state = entry_q[rd_ptr_q];
    assign blk_cnt       = blk_cnt_q;

    assign w_push    = bus.in_valid & bus.in_ready;
    assign w_pop     = bus.out_valid & bus.out_ready;
    assign w_shifted = f_shift(bus.in_state, bus.in_inv);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        blk_cnt_d = blk_cnt_q;
        if (w_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d  = ~rd_ptr_q;
            blk_cnt_d = blk_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            blk_cnt_q  <= '0;
        end else begin
            if (w_push) begin
                entry_q[wr_ptr_q] <= w_shifted;
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

`ifdef SHIFT_ROWS_SELFCHECK_EN
    logic [W-1:0] orig_q [2];
    logic [1:0]   inv_q;
    logic         chk_err_q;
    logic         w_chk_fail;

    // Undoing the transform on the popped entry must reproduce the stored input.
    assign w_chk_fail = w_pop &&
                        (f_shift(entry_q[rd_ptr_q], ~inv_q[rd_ptr_q]) != orig_q[rd_ptr_q]);
    assign chk_err    = chk_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            orig_q[0] <= '0;
            orig_q[1] <= '0;
            inv_q     <= 2'b00;
            chk_err_q <= 1'b0;
        end else begin
            if (w_push) begin
                orig_q[wr_ptr_q] <= bus.in_state;
                inv_q[wr_ptr_q]  <= bus.in_inv;
            end
            chk_err_q <= chk_err_q | w_chk_fail;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_rows_unit.sv
//==============================================================================
// Module      : tb_shift_rows_unit
// Description : Scoreboard bench for shift_rows_unit at NB = 4, 6 and 8.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_shift_rows_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_rows_unit_if #(.NB(4)) i4 ();
    shift_rows_unit_if #(.NB(6)) i6 ();
    shift_rows_unit_if #(.NB(8)) i8 ();

    logic [15:0] blk4, blk6, blk8;

`ifdef SHIFT_ROWS_SELFCHECK_EN
    logic e4, e6, e8;
    shift_rows_unit #(.NB(4)) u4 (.clk(clk), .rst(rst), .bus(i4), .blk_cnt(blk4), .chk_err(e4));
    shift_rows_unit #(.NB(6)) u6 (.clk(clk), .rst(rst), .bus(i6), .blk_cnt(blk6), .chk_err(e6));
    shift_rows_unit #(.NB(8)) u8 (.clk(clk), .rst(rst), .bus(i8), .blk_cnt(blk8), .chk_err(e8));
`else
    shift_rows_unit #(.NB(4)) u4 (.clk(clk), .rst(rst), .bus(i4), .blk_cnt(blk4));
    shift_rows_unit #(.NB(6)) u6 (.clk(clk), .rst(rst), .bus(i6), .blk_cnt(blk6));
    shift_rows_unit #(.NB(8)) u8 (.clk(clk), .rst(rst), .bus(i8), .blk_cnt(blk8));
`endif

    localparam logic [127:0] IN4 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] F4  = 128'h00050a0f_04090e03_080d0207_0c01060b;
    localparam logic [127:0] I4  = 128'h000d0a07_04010e0b_0805020f_0c090603;
    localparam logic [191:0] IN6 = 192'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617;
    localparam logic [191:0] F6  = 192'h00050a0f_04090e13_080d1217_0c111603_10150207_1401060b;
    localparam logic [191:0] I6  = 192'h0015120f_04011613_08050217_0c090603_100d0a07_14110e0b;
    localparam logic [255:0] IN8 = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
    localparam logic [255:0] F8  = 256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;
    localparam logic [255:0] I8  = 256'h001d1613_04011a17_08051e1b_0c09021f_100d0603_14110a07_18150e0b_1c19120f;

    logic [127:0] q4 [$];
    logic [191:0] q6 [$];
    logic [255:0] q8 [$];
    logic [15:0]  cnt4 = '0, cnt6 = '0, cnt8 = '0;
    int           pass_cnt = 0;
    int           tot_cnt  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            4:       return i4.in_ready;
            6:       return i6.in_ready;
            default: return i8.in_ready;
        endcase
    endfunction

    // Present one beat and hold it until accepted; expectation is queued up front.
    task automatic push(input int sel, input logic [255:0] d, input logic inv, input logic [255:0] e);
        logic acc;
        int   n;
        case (sel)
            4: begin i4.in_state = d[127:0]; i4.in_inv = inv; i4.in_valid = 1'b1; q4.push_back(e[127:0]); end
            6: begin i6.in_state = d[191:0]; i6.in_inv = inv; i6.in_valid = 1'b1; q6.push_back(e[191:0]); end
            default: begin i8.in_state = d; i8.in_inv = inv; i8.in_valid = 1'b1; q8.push_back(e); end
        endcase
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = rdy(sel);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("push_timeout", 256'd0, 256'd1);
        i4.in_valid = 1'b0;
        i6.in_valid = 1'b0;
        i8.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q4.size() + q6.size() + q8.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 256'(q4.size() + q6.size() + q8.size()), 256'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && i4.out_valid && i4.out_ready) begin
            if (q4.size() == 0) chk("u4_spurious", 256'd1, 256'd0);
            else chk("u4_data", 256'(i4.out_state), 256'(q4.pop_front()));
            chk("u4_blk_cnt", 256'(blk4), 256'(cnt4));
            cnt4 = cnt4 + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst && i6.out_valid && i6.out_ready) begin
            if (q6.size() == 0) chk("u6_spurious", 256'd1, 256'd0);
            else chk("u6_data", 256'(i6.out_state), 256'(q6.pop_front()));
            chk("u6_blk_cnt", 256'(blk6), 256'(cnt6));
            cnt6 = cnt6 + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst && i8.out_valid && i8.out_ready) begin
            if (q8.size() == 0) chk("u8_spurious", 256'd1, 256'd0);
            else chk("u8_data", i8.out_state, q8.pop_front());
            chk("u8_blk_cnt", 256'(blk8), 256'(cnt8));
            cnt8 = cnt8 + 16'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i4.in_valid = 1'b0; i4.in_inv = 1'b0; i4.in_state = '0; i4.out_ready = 1'b1;
        i6.in_valid = 1'b0; i6.in_inv = 1'b0; i6.in_state = '0; i6.out_ready = 1'b1;
        i8.in_valid = 1'b0; i8.in_inv = 1'b0; i8.in_state = '0; i8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", 256'(i4.out_valid), 256'd0);
        chk("rst_in_ready",  256'(i4.in_ready),  256'd1);
        chk("rst_blk_cnt",   256'(blk4),         256'd0);
        chk("rst_out_state", 256'(i4.out_state), 256'd0);

        // Single forward beat: visible right after the accepting edge.
        push(4, 256'(IN4), 1'b0, 256'(F4));
        chk("lat_out_valid", 256'(i4.out_valid), 256'd1);
        chk("lat_out_state", 256'(i4.out_state), 256'(F4));
        wait_drain();
        chk("t1_blk_cnt", 256'(blk4), 256'd1);

        push(4, 256'(IN4), 1'b1, 256'(I4));
        wait_drain();

        // Backpressure: two beats fill the FIFO, third is held off.
        i4.out_ready = 1'b0;
        push(4, 256'(IN4), 1'b0, 256'(F4));
        push(4, 256'(IN4), 1'b1, 256'(I4));
        fork
            push(4, 256'(~IN4), 1'b0, 256'(~F4));
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_in_ready",  256'(i4.in_ready),  256'd0);
                    chk("full_out_valid", 256'(i4.out_valid), 256'd1);
                    chk("full_hold",      256'(i4.out_state), 256'(F4));
                end
                @(posedge clk);
                #1;
                i4.out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("t3_blk_cnt", 256'(blk4), 256'd5);

        // Wider blocks, alternating direction, plus round trips.
        push(6, 256'(IN6), 1'b0, 256'(F6));
        push(6, 256'(IN6), 1'b1, 256'(I6));
        push(6, 256'(F6),  1'b1, 256'(IN6));
        push(6, 256'(I6),  1'b0, 256'(IN6));
        push(8, IN8, 1'b0, F8);
        push(8, IN8, 1'b1, I8);
        push(8, F8,  1'b1, IN8);
        push(8, I8,  1'b0, IN8);
        wait_drain();
        chk("t4_blk6", 256'(blk6), 256'd4);
        chk("t4_blk8", 256'(blk8), 256'd4);

        // Reset with the FIFO full discards both beats.
        i4.out_ready = 1'b0;
        push(4, 256'(IN4), 1'b0, 256'(F4));
        push(4, 256'(IN4), 1'b1, 256'(I4));
        chk("pre_rst_full", 256'(i4.in_ready), 256'd0);
        rst = 1'b1;
        q4.delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        cnt4 = '0;
        cnt6 = '0;
        cnt8 = '0;
        chk("t5_out_valid", 256'(i4.out_valid), 256'd0);
        chk("t5_in_ready",  256'(i4.in_ready),  256'd1);
        chk("t5_blk_cnt",   256'(blk4),         256'd0);
        chk("t5_out_state", 256'(i4.out_state), 256'd0);
        chk("t5_blk8",      256'(blk8),         256'd0);
        i4.out_ready = 1'b1;
        push(4, 256'(IN4), 1'b1, 256'(I4));
        wait_drain();
        chk("t5_post_blk", 256'(blk4), 256'd1);

`ifdef SHIFT_ROWS_SELFCHECK_EN
        chk("chk_err4", 256'(e4), 256'd0);
        chk("chk_err6", 256'(e6), 256'd0);
        chk("chk_err8", 256'(e8), 256'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

`default_nettype wire
